// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NZCV flag layout and status-register FSM encoding.
package cpu_pkg;

   localparam int SR_W   = 4;
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {
      SR_IDLE = 1'b0,
      SR_PEND = 1'b1
   } sr_state_e;

endpackage

// File: rtl/sr_pend_fsm.sv
// Tracks one in-flight multi-cycle flag write: IDLE/PEND state plus an
// abandon-timeout counter. Reports completion, stray completions and timeouts.
module sr_pend_fsm
   import cpu_pkg::*;
#(
   parameter int MC_TIMEOUT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic start,     // gated mc_start
   input  logic done,      // mc_valid (never gated)
   output logic busy,      // pending write outstanding
   output logic take,      // completion accepted this cycle
   output logic stray,     // completion arrived with nothing pending
   output logic timeout    // pending write abandoned this cycle
);

   localparam int CNT_W = $clog2(MC_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_TIMEOUT - 1);

   sr_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   // State and counter registers; reset abandons any pending write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SR_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state, counter and event outputs; counter only moves while nonzero.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      take      = 1'b0;
      stray     = 1'b0;
      timeout   = 1'b0;
      case (state)
         SR_IDLE: begin
            stray = done;
            if (start) begin
               state_nxt = SR_PEND;
               cnt_nxt   = CNT_LOAD;
            end
         end
         SR_PEND: begin
            if (done) begin
               take      = 1'b1;
               state_nxt = SR_IDLE;
            end else if (cnt == '0) begin
               timeout   = 1'b1;
               state_nxt = SR_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: state_nxt = SR_IDLE;
      endcase
   end

   assign busy = (state == SR_PEND);

endmodule

// File: rtl/status_register.sv
// Architectural NZCV status register: write-priority mux for ALU, MSR and
// multi-cycle sources, forwarding to the condition check, sticky error flag.
module status_register
   import cpu_pkg::*;
#(
   parameter int MC_TIMEOUT = 8,
   parameter int FWD_EN     = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            flush,
   input  logic            s_upd,
   input  logic            n_in,
   input  logic            z_in,
   input  logic            c_in,
   input  logic            v_in,
   input  logic            mc_start,
   input  logic            mc_valid,
   input  logic [SR_W-1:0] mc_flags,
   input  logic            msr_we,
   input  logic [SR_W-1:0] msr_data,
   input  logic            err_clr,
   output logic [SR_W-1:0] sr,
   output logic [SR_W-1:0] cond_flags,
   output logic            flags_busy,
   output logic            err
);

   logic            gate;
   logic            upd_ok, msr_ok, start_ok;
   logic            mc_take, mc_stray, mc_timeout;
   logic            err_evt;
   logic [SR_W-1:0] alu_flags;
   logic [SR_W-1:0] sr_nxt;

   assign gate     = freeze | flush;
   assign upd_ok   = s_upd & ~gate;
   assign msr_ok   = msr_we & ~gate;
   assign start_ok = mc_start & ~gate;

   sr_pend_fsm #(
      .MC_TIMEOUT(MC_TIMEOUT)
   ) u_pend (
      .clk     (clk),
      .rst     (rst),
      .start   (start_ok),
      .done    (mc_valid),
      .busy    (flags_busy),
      .take    (mc_take),
      .stray   (mc_stray),
      .timeout (mc_timeout)
   );

   // Pack the ALU flags in NZCV order.
   always_comb begin
      alu_flags         = '0;
      alu_flags[FLAG_N] = n_in;
      alu_flags[FLAG_Z] = z_in;
      alu_flags[FLAG_C] = c_in;
      alu_flags[FLAG_V] = v_in;
   end

   // Next flag value: completion while pending, else ALU over MSR while idle.
   always_comb begin
      sr_nxt  = sr;
      err_evt = mc_stray | mc_timeout;
      if (flags_busy) begin
         if (mc_take) sr_nxt = mc_flags;
         if (upd_ok | msr_ok | start_ok) err_evt = 1'b1;
      end else begin
         if (upd_ok)      sr_nxt = alu_flags;
         else if (msr_ok) sr_nxt = msr_data;
         if (upd_ok & msr_ok) err_evt = 1'b1;
      end
   end

   // Flag register and sticky error; a new error outranks a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         err <= 1'b0;
      end else begin
         sr <= sr_nxt;
         if (err_evt)      err <= 1'b1;
         else if (err_clr) err <= 1'b0;
      end
   end

   assign cond_flags = (FWD_EN != 0) ? sr_nxt : sr;

endmodule

// File: tb/tb_status_register.sv
// Scoreboarded bench for status_register: directed scenarios then random traffic.
module tb_status_register;

   localparam int MC_TIMEOUT = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       freeze = 0, flush = 0, s_upd = 0;
   logic       n_in = 0, z_in = 0, c_in = 0, v_in = 0;
   logic       mc_start = 0, mc_valid = 0, msr_we = 0, err_clr = 0;
   logic [3:0] mc_flags = 0, msr_data = 0;
   logic [3:0] sr, cond_flags, sr_b, cond_b;
   logic       flags_busy, err, busy_b, err_b;

   int errors = 0;
   int checks = 0;
   bit drive_done = 0;

   typedef struct packed {
      logic [3:0] sr;
      logic [3:0] cond;
      logic       busy;
      logic       err;
   } exp_t;
   exp_t q[$];

   // behavioural reference state
   logic [3:0] m_sr;
   bit         m_err, m_busy;
   int         m_left;

   always #5 clk = ~clk;

   status_register #(.MC_TIMEOUT(MC_TIMEOUT), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .s_upd(s_upd),
      .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
      .mc_start(mc_start), .mc_valid(mc_valid), .mc_flags(mc_flags),
      .msr_we(msr_we), .msr_data(msr_data), .err_clr(err_clr),
      .sr(sr), .cond_flags(cond_flags), .flags_busy(flags_busy), .err(err)
   );

   status_register #(.MC_TIMEOUT(MC_TIMEOUT), .FWD_EN(0)) dut_nofwd (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .s_upd(s_upd),
      .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
      .mc_start(mc_start), .mc_valid(mc_valid), .mc_flags(mc_flags),
      .msr_we(msr_we), .msr_data(msr_data), .err_clr(err_clr),
      .sr(sr_b), .cond_flags(cond_b), .flags_busy(busy_b), .err(err_b)
   );

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every falling edge compares the DUT against the oldest expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check("sr",         sr,                 e.sr);
         check("cond_flags", cond_flags,         e.cond);
         check("flags_busy", {3'b0, flags_busy}, {3'b0, e.busy});
         check("err",        {3'b0, err},        {3'b0, e.err});
         check("nofwd_cond", cond_b,             e.sr);
      end
   end

   task automatic model_reset();
      m_sr = 4'b0; m_err = 0; m_busy = 0; m_left = 0;
   endtask

   // Reference model: applies one cycle of inputs, pushes what the monitor should see.
   task automatic model_step(input bit su, input logic [3:0] alu, input bit ms,
                             input logic [3:0] md, input bit st, input bit mv,
                             input logic [3:0] mf, input bit g, input bit ec);
      logic [3:0] nsr;
      bit ev, nbusy;
      exp_t e;
      nsr = m_sr; ev = 0; nbusy = m_busy;
      if (!m_busy) begin
         if (su && !g)      nsr = alu;
         else if (ms && !g) nsr = md;
         if (su && ms && !g) ev = 1;
         if (mv) ev = 1;
         if (st && !g) begin nbusy = 1; m_left = MC_TIMEOUT; end
      end else begin
         if ((su || ms || st) && !g) ev = 1;
         if (mv) begin nsr = mf; nbusy = 0; end
         else if (m_left == 1) begin nbusy = 0; ev = 1; end
         else m_left--;
      end
      e.sr = m_sr; e.cond = nsr; e.busy = m_busy; e.err = m_err;
      q.push_back(e);
      m_sr = nsr;
      m_busy = nbusy;
      if (ev) m_err = 1;
      else if (ec) m_err = 0;
   endtask

   task automatic cyc(input bit su = 0, input logic [3:0] alu = 0, input bit ms = 0,
                      input logic [3:0] md = 0, input bit st = 0, input bit mv = 0,
                      input logic [3:0] mf = 0, input bit fr = 0, input bit fl = 0,
                      input bit ec = 0);
      @(posedge clk); #1;
      rst = 0;
      s_upd = su; {n_in, z_in, c_in, v_in} = alu;
      msr_we = ms; msr_data = md; mc_start = st; mc_valid = mv; mc_flags = mf;
      freeze = fr; flush = fl; err_clr = ec;
      model_step(su, alu, ms, md, st, mv, mf, fr | fl, ec);
   endtask

   task automatic do_reset();
      exp_t e;
      @(posedge clk); #1;
      s_upd = 0; msr_we = 0; mc_start = 0; mc_valid = 0; freeze = 0; flush = 0; err_clr = 0;
      rst = 1;
      model_reset();
      e.sr = 4'b0; e.cond = 4'b0; e.busy = 0; e.err = 0;
      q.push_back(e);
   endtask

   initial begin
      model_reset();
      do_reset();
      // ALU write with forwarding
      cyc(.su(1), .alu(4'b1010));
      cyc();
      // gated writes are dropped without error
      cyc(.su(1), .alu(4'b1111), .fr(1));
      cyc();
      cyc(.su(1), .alu(4'b1111), .fl(1));
      cyc();
      // multi-cycle completion after three cycles
      cyc(.st(1));
      cyc(); cyc();
      cyc(.mv(1), .mf(4'b0100));
      cyc(); cyc();
      // timeout, then stray completion
      cyc(.st(1));
      for (int i = 0; i < MC_TIMEOUT + 1; i++) cyc();
      cyc(.mv(1), .mf(4'b1111));
      cyc();
      // ALU and MSR collide, then clear
      cyc(.ec(1));
      cyc(.su(1), .alu(4'b0110), .ms(1), .md(4'b0001));
      cyc();
      cyc(.ec(1));
      cyc();
      cyc(.ms(1), .md(4'b0011));
      cyc();
      // reset while pending, then stray completion
      cyc(.st(1));
      cyc();
      do_reset();
      cyc(.mv(1), .mf(4'b1001));
      cyc();
      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc(.su($urandom_range(0, 3) == 0), .alu(4'($urandom)),
             .ms($urandom_range(0, 5) == 0), .md(4'($urandom)),
             .st($urandom_range(0, 7) == 0),
             .mv($urandom_range(0, m_busy ? 4 : 30) == 0), .mf(4'($urandom)),
             .fr($urandom_range(0, 9) == 0), .fl($urandom_range(0, 11) == 0),
             .ec($urandom_range(0, 6) == 0));
      end
      cyc();
      drive_done = 1;
   end

   initial begin
      int waited;
      wait (drive_done);
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(posedge clk);
         waited++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/status_register.md
Name: status_register

Overview:
Flag-producer counterpart to the condition checker: owns the architectural NZCV status register. It captures flags from flag-setting ALU instructions, multi-cycle (multiply) completions and MSR-style software writes. It sits at the EXE stage and feeds both the registered and the forwarded flags back to the ID-stage condition check. It also tracks in-flight multi-cycle flag writes, so the pipeline can stall conditional instructions.

Parameters:
MC_TIMEOUT, 8, max cycles from mc_start to mc_valid before the pending write is abandoned (>=1)
FWD_EN, 1, 1: cond_flags bypasses the next-state flags; 0: cond_flags = sr

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  pipeline stall; blocks new updates from the EXE instruction
flush  in  1  kills the current EXE instruction's flag effects this cycle
s_upd  in  1  EXE instruction with S bit is valid this cycle
n_in, z_in, c_in, v_in  in  1 each  ALU flags for s_upd
mc_start  in  1  multi-cycle flag-setting op issued
mc_valid  in  1  multi-cycle op completes; mc_flags valid
mc_flags  in  4  {N,Z,C,V} from the multi-cycle unit
msr_we  in  1  software write to flags
msr_data  in  4  {N,Z,C,V} software value
err_clr  in  1  clears err
sr  out  4  registered {N,Z,C,V}
cond_flags  out  4  flags presented to the condition check
flags_busy  out  1  multi-cycle flag write pending
err  out  1  sticky protocol-violation flag

Behaviour:
- Async reset: sr=4'b0000, err=0, flags_busy=0, FSM=IDLE, timeout counter=0. Reset mid-PEND abandons the pending write.
- Bit order everywhere: [3]=N, [2]=Z, [1]=C, [0]=V.
- gate = freeze | flush. When gate=1, s_upd, msr_we and mc_start are ignored that cycle with no err. mc_valid and the timeout counter are unaffected by gate.
- FSM has two states: IDLE and PEND. flags_busy = (state==PEND), registered.
- IDLE:
  - mc_start & !gate -> PEND; counter loaded with MC_TIMEOUT-1.
  - s_upd & !gate -> sr <= {n_in,z_in,c_in,v_in} at the next edge (1-cycle latency).
  - msr_we & !gate & !s_upd -> sr <= msr_data.
  - s_upd & msr_we together -> the s_upd value wins and err <= 1.
  - mc_valid in IDLE -> ignored, err <= 1.
  - mc_start together with s_upd -> both taken: the s_upd write happens now and the FSM enters PEND.
- PEND:
  - mc_valid -> sr <= mc_flags, go to IDLE. Accepted even when counter==0 in that cycle.
  - Otherwise, if counter==0 -> go to IDLE, sr unchanged, err <= 1 (timeout). Else counter decrements.
  - s_upd, msr_we or mc_start (any, !gate) -> ignored, err <= 1. The pipeline must stall these while flags_busy.
  - mc_valid with a simultaneous mc_start -> the completion is taken, mc_start raises err, and the FSM returns to IDLE.
- cond_flags with FWD_EN=1 equals combinationally the value sr will hold after the next edge. With FWD_EN=0 it equals sr.
- err is sticky. err_clr clears it at the next edge; an error event in the same cycle as err_clr wins (err stays 1).
- Counter width is clog2(MC_TIMEOUT)+1. It never wraps, because it only decrements while nonzero.

Decomposition:
- Shared package (cpu_pkg):
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - SR_W=4
  - FSM state encoding SR_IDLE=1'b0, SR_PEND=1'b1
  - the condition checker uses the same flag indices
- One natural sub-module: sr_pend_fsm. It holds the IDLE/PEND state, the timeout counter, and the flags_busy and timeout-error outputs.
- The top holds the sr register, write-priority mux, forwarding mux and err register.

Test Plan:
- Reset, then s_upd=1 with n,z,c,v = 1,0,1,0 -> sr=4'b1010 one cycle later. cond_flags=4'b1010 in the same cycle when FWD_EN=1.
- s_upd=1 with freeze=1, flags 1111 -> sr unchanged, err=0. Repeat with flush=1 -> same result.
- mc_start, then mc_valid with mc_flags=4'b0100 three cycles later -> flags_busy=1 for those cycles, sr=4'b0100, flags_busy=0 the cycle after.
- mc_start with MC_TIMEOUT=8 and no mc_valid -> flags_busy drops after 8 cycles, err=1, sr unchanged. A later mc_valid in IDLE -> ignored, err stays 1.
- s_upd=1 and msr_we=1 together with msr_data=4'b0001 and ALU flags 0110 -> sr=4'b0110, err=1. err_clr -> err=0 next cycle.
- rst asserted mid-PEND -> immediate sr=0, flags_busy=0. A subsequent mc_valid leaves sr=0 and sets err=1.
